audio_dac_serializer: RTL and testbench

//  Transmit-side audio serializer: drives the DACDAT line of the audio codec conduit.
//  The codec is bit/frame-clock master: BCLK and DACLRC are inputs, oversampled by clk_clk.

---
 rtl/audio_dac_serializer.sv | 220 ++++++++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// Transmit-side audio serializer: buffers stereo samples in a small FIFO and shifts
// them MSB-first onto DACDAT against a codec-mastered BCLK/DACLRC (I2S or left-justified).
module audio_dac_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter bit I2S_MODE   = 1'b1
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic                          bclk_in,
   input  logic                          daclrc_in,
   input  logic [2*DATA_WIDTH-1:0]       s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          dacdat,
   output logic                          underflow,
   output logic [15:0]                   underflow_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DW    = DATA_WIDTH;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int CW    = $clog2(DATA_WIDTH + 1);

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } state_e;

   // ------------------------------------------------------------------
   // BCLK / DACLRC synchronizers and edge detection
   // ------------------------------------------------------------------
   logic bclk_s1_q, bclk_s2_q, bclk_d1_q;
   logic lrc_s1_q, lrc_s2_q, lrc_q;
   logic bclk_fall, boundary, frame_start;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         bclk_s1_q <= 1'b0;
         bclk_s2_q <= 1'b0;
         bclk_d1_q <= 1'b0;
         lrc_s1_q  <= 1'b0;
         lrc_s2_q  <= 1'b0;
         lrc_q     <= 1'b0;
      end else begin
         bclk_s1_q <= bclk_in;
         bclk_s2_q <= bclk_s1_q;
         bclk_d1_q <= bclk_s2_q;
         lrc_s1_q  <= daclrc_in;
         lrc_s2_q  <= lrc_s1_q;
         if (bclk_fall) begin
            lrc_q <= lrc_s2_q;
         end
      end
   end

   assign bclk_fall   = bclk_d1_q & ~bclk_s2_q;
   assign boundary    = bclk_fall & (lrc_s2_q != lrc_q);
   // A left channel begins when DACLRC drops: that is the only point a new frame is loaded.
   assign frame_start = boundary & ~lrc_s2_q;

   // ------------------------------------------------------------------
   // Sample FIFO
   // ------------------------------------------------------------------
   logic [2*DW-1:0]  mem_q [FIFO_DEPTH];
   logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             fifo_empty, push, pop, pop_req;
   logic [2*DW-1:0]  pop_word;

   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign s_ready    = (fifo_level != LVL_W'(FIFO_DEPTH));
   assign push       = s_valid & s_ready;
   assign pop        = pop_req & ~fifo_empty;
   assign pop_word   = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d   = wr_ptr_q + LVL_W'(push);
   assign rd_ptr_d   = rd_ptr_q + LVL_W'(pop);

   // NOTE: storage array carries no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= s_data;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   state_e state_q, state_d;
   logic   ser_en;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_SYNC: if (frame_start) state_d = RUN;
         RUN:       state_d = RUN;
         default:   state_d = WAIT_SYNC;
      endcase
   end

   // The frame start that leaves WAIT_SYNC already pops and serializes its left channel.
   always_comb begin
      pop_req = 1'b0;
      ser_en  = 1'b0;
      case (state_q)
         WAIT_SYNC: begin
            pop_req = frame_start;
            ser_en  = frame_start;
         end
         RUN: begin
            pop_req = frame_start;
            ser_en  = bclk_fall;
         end
         default: begin
            pop_req = 1'b0;
            ser_en  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Frame register, channel shifter and DACDAT
   // ------------------------------------------------------------------
   logic [2*DW-1:0] frame_q, frame_d;
   logic [DW-1:0]   sh_q, sh_d, load_word;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            dacdat_q, dacdat_d;

   always_comb begin
      frame_d   = frame_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      dacdat_d  = dacdat_q;
      if (frame_start) begin
         frame_d = pop_word;
      end
      load_word = lrc_s2_q ? frame_d[DW-1:0] : frame_d[2*DW-1:DW];
      if (ser_en) begin
         if (boundary) begin
            if (I2S_MODE) begin
               dacdat_d  = 1'b0;
               sh_d      = load_word;
               bit_cnt_d = '0;
            end else begin
               dacdat_d  = load_word[DW-1];
               sh_d      = {load_word[DW-2:0], 1'b0};
               bit_cnt_d = CW'(1);
            end
         end else begin
            // bit_cnt counts bits already emitted from this slot's word; past DW the slot pads with 0.
            dacdat_d = (bit_cnt_q < CW'(DW)) ? sh_q[DW-1] : 1'b0;
            sh_d     = {sh_q[DW-2:0], 1'b0};
            if (bit_cnt_q < CW'(DW)) begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         frame_q   <= '0;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         dacdat_q  <= 1'b0;
      end else begin
         frame_q   <= frame_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         dacdat_q  <= dacdat_d;
      end
   end

   // ------------------------------------------------------------------
   // Underflow reporting
   // ------------------------------------------------------------------
   logic        underflow_q, underflow_d;
   logic [15:0] underflow_cnt_q, underflow_cnt_d;

   assign underflow_d     = pop_req & fifo_empty;
   assign underflow_cnt_d = (underflow_d && (underflow_cnt_q != 16'hFFFF))
                            ? underflow_cnt_q + 16'd1 : underflow_cnt_q;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         underflow_q     <= 1'b0;
         underflow_cnt_q <= '0;
      end else begin
         underflow_q     <= underflow_d;
         underflow_cnt_q <= underflow_cnt_d;
      end
   end

   assign dacdat        = dacdat_q;
   assign underflow     = underflow_q;
   assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: one I2S and one left-justified instance share all stimulus;
// DACDAT is compared bit-by-bit against a slot/bit-index model of the serial format.
module tb_audio_dac_serializer;

   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          clk_clk, reset_reset, bclk_in, daclrc_in;
   logic [2*DW-1:0] s_data;
   logic          s_valid;

   logic          s_ready, dacdat, underflow;
   logic [15:0]   underflow_cnt;
   logic [2:0]    fifo_level;
   logic          s_ready_lj, dacdat_lj, underflow_lj;
   logic [15:0]   underflow_cnt_lj;
   logic [2:0]    fifo_level_lj;

   int vectors     = 0;
   int miscompares = 0;

   audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1'b1)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .bclk_in(bclk_in), .daclrc_in(daclrc_in),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dacdat(dacdat),
      .underflow(underflow), .underflow_cnt(underflow_cnt), .fifo_level(fifo_level));

   audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1'b0)) dut_lj (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .bclk_in(bclk_in), .daclrc_in(daclrc_in),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_lj), .dacdat(dacdat_lj),
      .underflow(underflow_lj), .underflow_cnt(underflow_cnt_lj), .fifo_level(fifo_level_lj));

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   // Underflow pulses observed on each instance.
   int pulses_a = 0;
   int pulses_b = 0;
   always @(negedge clk_clk) begin
      if (underflow === 1'b1)    pulses_a++;
      if (underflow_lj === 1'b1) pulses_b++;
   end

   // Reference model: FIFO as a queue, serial position as a bit index within the slot.
   logic [2*DW-1:0] m_q[$];
   logic [2*DW-1:0] m_frame;
   logic [DW-1:0]   m_word;
   logic            m_lrc, m_run;
   int              m_idx, m_uf;
   int              m_pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_frame = '0;
      m_word  = '0;
      m_lrc   = 1'b0;
      m_run   = 1'b0;
      m_idx   = 0;
      m_uf    = 0;
   endtask

   // Expected DACDAT after a BCLK fall on which DACLRC reads lrc.
   task automatic model_fall(input logic lrc, output logic e_i2s, output logic e_lj);
      if (lrc != m_lrc) begin
         if (!lrc) begin
            m_run = 1'b1;
            if (m_q.size() == 0) begin
               m_frame = '0;
               m_pulses++;
               if (m_uf < 65535) m_uf++;
            end else begin
               m_frame = m_q.pop_front();
            end
         end
         m_word = lrc ? m_frame[DW-1:0] : m_frame[2*DW-1:DW];
         m_idx  = 0;
      end else if (m_idx < 1000) begin
         m_idx++;
      end
      m_lrc = lrc;
      e_lj  = (m_run && m_idx < DW) ? m_word[DW-1-m_idx] : 1'b0;
      e_i2s = (m_run && m_idx >= 1 && m_idx <= DW) ? m_word[DW-m_idx] : 1'b0;
   endtask

   // One BCLK period (8 clk): fall with new DACLRC, rise after 4 clk, sample 5 clk after the fall.
   task automatic slot(input logic lrc);
      logic e_i2s, e_lj;
      @(negedge clk_clk);
      bclk_in   = 1'b0;
      daclrc_in = lrc;
      model_fall(lrc, e_i2s, e_lj);
      repeat (4) @(negedge clk_clk);
      bclk_in = 1'b1;
      @(negedge clk_clk);
      check("dacdat_i2s", dacdat, e_i2s);
      check("dacdat_lj", dacdat_lj, e_lj);
      repeat (2) @(negedge clk_clk);
   endtask

   task automatic frame(input int llen, input int rlen);
      for (int i = 0; i < llen; i++) slot(1'b0);
      for (int i = 0; i < rlen; i++) slot(1'b1);
   endtask

   task automatic push(input logic [2*DW-1:0] d);
      int waited;
      waited = 0;
      @(negedge clk_clk);
      s_data  = d;
      s_valid = 1'b1;
      while (!s_ready && waited < 20) begin
         @(negedge clk_clk);
         waited++;
      end
      check("push_accept", s_ready, 1'b1);
      if (s_ready) m_q.push_back(d);
      @(negedge clk_clk);
      s_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_dacdat"}, dacdat, 1'b0);
      check({tag, "_dacdat_lj"}, dacdat_lj, 1'b0);
      check({tag, "_s_ready"}, s_ready, 1'b1);
      check({tag, "_level"}, fifo_level, 3'd0);
      check({tag, "_ufcnt"}, underflow_cnt, 16'd0);
      check({tag, "_ufcnt_lj"}, underflow_cnt_lj, 16'd0);
      check({tag, "_uf"}, underflow, 1'b0);
   endtask

   initial begin
      logic        e_i2s, e_lj;
      logic [31:0] e5;
      int          waited;

      s_data      = '0;
      s_valid     = 1'b0;
      bclk_in     = 1'b1;
      daclrc_in   = 1'b1;
      reset_reset = 1'b1;
      model_reset();
      repeat (3) @(negedge clk_clk);
      check_idle_outputs("reset");

      // Release in the middle of a right channel: nothing pops until DACLRC falls.
      reset_reset = 1'b0;
      push(32'h8001_1234);
      push($urandom);
      repeat (4) slot(1'b1);
      check("no_pop_before_sync", fifo_level, 3'd2);
      frame(32, 32);
      check("level_after_first_frame", fifo_level, 3'd1);
      frame(32, 32);

      // Directed slot lengths: exact, one over, truncated.
      push(32'h8001_1234); frame(32, 32);
      push($urandom);      frame(16, 16);
      push($urandom);      frame(17, 17);
      push($urandom);      frame(10, 12);
      for (int f = 0; f < 4; f++) begin
         push($urandom);
         frame($urandom_range(10, 34), $urandom_range(10, 34));
      end
      check("ufcnt_none", underflow_cnt, m_uf);

      // Three frames with an empty FIFO.
      repeat (3) frame(18, 18);
      check("ufcnt_3", underflow_cnt, m_uf);
      check("ufcnt_3_lj", underflow_cnt_lj, m_uf);
      check("uf_pulses", pulses_a, m_pulses);
      check("uf_pulses_lj", pulses_b, m_pulses);

      // Saturation: preset the counter to its ceiling, then underflow again.
      @(negedge clk_clk);
      force dut.underflow_cnt_q    = 16'hFFFF;
      force dut_lj.underflow_cnt_q = 16'hFFFF;
      @(negedge clk_clk);
      release dut.underflow_cnt_q;
      release dut_lj.underflow_cnt_q;
      m_uf = 65535;
      frame(18, 18);
      check("ufcnt_sat", underflow_cnt, m_uf);
      check("ufcnt_sat_lj", underflow_cnt_lj, m_uf);
      check("uf_pulses_sat", pulses_a, m_pulses);

      // Backpressure: fill the FIFO, hold a 5th sample, release it with one frame start.
      for (int i = 0; i < DEPTH; i++) push($urandom);
      check("full_level", fifo_level, 3'd4);
      check("full_ready", s_ready, 1'b0);
      e5 = $urandom;
      @(negedge clk_clk);
      s_data  = e5;
      s_valid = 1'b1;
      repeat (3) @(negedge clk_clk);
      check("held_ready", s_ready, 1'b0);
      check("held_level", fifo_level, 3'd4);
      bclk_in   = 1'b0;
      daclrc_in = 1'b0;
      model_fall(1'b0, e_i2s, e_lj);
      waited = 0;
      while (fifo_level == 3'd4 && waited < 10) begin
         @(negedge clk_clk);
         waited++;
      end
      check("pop_level", fifo_level, 3'd3);
      check("pop_ready", s_ready, 1'b1);
      @(negedge clk_clk);
      check("held_accepted_level", fifo_level, 3'd4);
      m_q.push_back(e5);
      s_valid = 1'b0;
      bclk_in = 1'b1;
      @(negedge clk_clk);
      check("bp_dacdat_i2s", dacdat, e_i2s);
      check("bp_dacdat_lj", dacdat_lj, e_lj);
      repeat (2) @(negedge clk_clk);
      frame(31, 32);
      repeat (4) frame(20, 20);
      check("drained_level", fifo_level, 3'd0);
      check("ufcnt_after_bp", underflow_cnt, m_uf);

      // Asynchronous reset in the middle of a left channel carrying ones.
      push(32'hFFFF_FFFF);
      push($urandom);
      repeat (5) slot(1'b0);
      @(negedge clk_clk);
      #2 reset_reset = 1'b1;
      #1;
      model_reset();
      check_idle_outputs("midreset");
      repeat (3) @(negedge clk_clk);
      reset_reset = 1'b0;
      push($urandom);
      repeat (3) slot(1'b0);
      check("no_pop_after_reset", fifo_level, 3'd1);
      repeat (2) slot(1'b1);
      frame(32, 32);
      check("level_after_resync", fifo_level, 3'd0);
      check("ufcnt_after_resync", underflow_cnt, m_uf);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
